// File: rtl/wallclock_display_pkg.sv
// Shared constants for the wall-clock display path: segment encodings,
// digit positions and the slot phase type used by the scanner.
package wallclock_display_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam int IDX_SEC_ONES = 0;
    localparam int IDX_SEC_TENS = 1;
    localparam int IDX_MIN_ONES = 2;
    localparam int IDX_MIN_TENS = 3;
    localparam int IDX_HR_ONES  = 4;
    localparam int IDX_HR_TENS  = 5;

    // Colon dots sit on the ones digit of minutes and hours
    localparam logic [5:0] COLON_MASK = (6'b000001 << IDX_MIN_ONES) |
                                        (6'b000001 << IDX_HR_ONES);

    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD shows a dash.
module seg7_decode
    import wallclock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup, anything above 9 renders as a dash
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Six-digit multiplexed display scanner with per-frame snapshot, guard gap,
// leading-zero blanking and blink support.
//
// slot state | meaning
// -----------+-----------------------------------------------
// SLOT_GUARD | slotCnt < GUARD: all anodes off (anti-ghosting)
// SLOT_DRIVE | remaining slot cycles: anode of digitIdx driven
module display_scanner
    import wallclock_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 50,
    parameter int BLINK_FRAMES = 60
) (
    input  logic        inputClock,
    input  logic        reset,
    input  logic [23:0] digits,
    input  logic [5:0]  blinkMask,
    input  logic        blankLeadingZero,
    input  logic        colonEn,
    output logic [5:0]  anode,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        frameStart
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [SW-1:0] slotCnt, slotNext;
    logic [2:0]    digitIdx, digitNext;
    logic [FW-1:0] frameCnt, frameNext;
    logic          blinkPhase, phaseNext;
    logic [23:0]   snapshot, snapNext;
    logic          frameStartNext;

    slot_state_t   slotState;
    logic [3:0]    nibble;
    logic [6:0]    decoded;
    logic [5:0]    anodeNext;
    logic [6:0]    segNext;
    logic          dpNext;

    seg7_decode u_decode (
        .bcd (nibble),
        .seg (decoded)
    );

    // Scan counters, blink timing and the frame snapshot
    always_comb begin
        slotNext       = slotCnt + 1'b1;
        digitNext      = digitIdx;
        frameNext      = frameCnt;
        phaseNext      = blinkPhase;
        snapNext       = snapshot;
        frameStartNext = 1'b0;
        if (slotCnt == SLOT_LAST) begin
            slotNext = '0;
            if (digitIdx == DIGIT_LAST) begin
                digitNext = '0;
                if (frameCnt == FRAME_LAST) begin
                    frameNext = '0;
                    phaseNext = ~blinkPhase;
                end else begin
                    frameNext = frameCnt + 1'b1;
                end
            end else begin
                digitNext = digitIdx + 1'b1;
            end
        end
        // The first slot of a frame is always a guard cycle, so the fresh
        // snapshot is ready before any digit is driven from it.
        if (digitIdx == '0 && slotCnt == '0) begin
            snapNext       = digits;
            frameStartNext = 1'b1;
        end
    end

    // Select the nibble for the digit currently being scanned
    always_comb begin
        nibble = '0;
        case (digitIdx)
            3'(IDX_SEC_ONES): nibble = snapshot[3:0];
            3'(IDX_SEC_TENS): nibble = snapshot[7:4];
            3'(IDX_MIN_ONES): nibble = snapshot[11:8];
            3'(IDX_MIN_TENS): nibble = snapshot[15:12];
            3'(IDX_HR_ONES):  nibble = snapshot[19:16];
            3'(IDX_HR_TENS):  nibble = snapshot[23:20];
            default:          nibble = '0;
        endcase
    end

    // Slot phase and the output values it implies
    always_comb begin
        slotState = (slotCnt < GUARD_END) ? SLOT_GUARD : SLOT_DRIVE;
        anodeNext = 6'h3F;
        segNext   = SEG_BLANK;
        dpNext    = 1'b1;
        case (slotState)
            SLOT_DRIVE: begin
                anodeNext = ~(6'b000001 << digitIdx);
                if (blinkMask[digitIdx] && blinkPhase) begin
                    segNext = SEG_BLANK;
                end else if (digitIdx == 3'(IDX_HR_TENS) && blankLeadingZero &&
                             nibble == 4'd0) begin
                    segNext = SEG_BLANK;
                end else begin
                    segNext = decoded;
                end
                // Blanking never hides the colon
                dpNext = ~(colonEn && COLON_MASK[digitIdx]);
            end
            default: begin
                anodeNext = 6'h3F;
            end
        endcase
    end

    // State and registered outputs, synchronous reset back to digit 0 slot 0
    always_ff @(posedge inputClock) begin
        if (reset) begin
            slotCnt    <= '0;
            digitIdx   <= '0;
            frameCnt   <= '0;
            blinkPhase <= 1'b0;
            snapshot   <= '0;
            anode      <= 6'h3F;
            segments   <= SEG_BLANK;
            dp         <= 1'b1;
            frameStart <= 1'b0;
        end else begin
            slotCnt    <= slotNext;
            digitIdx   <= digitNext;
            frameCnt   <= frameNext;
            blinkPhase <= phaseNext;
            snapshot   <= snapNext;
            anode      <= anodeNext;
            segments   <= segNext;
            dp         <= dpNext;
            frameStart <= frameStartNext;
        end
    end

endmodule
